spi_target: RTL and testbench

SPI mode-0 target (slave) engine clocked from the 48 MHz master clock. It is the far end of the CPLD's bit-banged SPI master, where SCLK toggles on accesses to $FE2E/$FE2F, MOSI is written via $FE31 bit 7, and nSD0/nSD1 select the device. The block receives MOSI bytes, returns queued bytes on MISO, and hands both to local logic through simple level handshakes. It lets a second CPLD or a bench model act as an SPI peripheral on the SD-card bus.

---
 rtl/spi_target_if.sv | 25 ++
 rtl/spi_target.sv | 150 +++++++++++++++
 tb/tb_spi_target.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// SPI pin bundle plus the local TX/RX level handshakes for spi_target.
interface spi_target_if;
    logic       nCS;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       MISO_OE;
    logic [7:0] TX_DATA;
    logic       TX_LOAD;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_ACK;
    logic       OVERRUN;

    modport master (
        output nCS, SCLK, MOSI, TX_DATA, TX_LOAD, RX_ACK,
        input  MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, OVERRUN
    );

    modport slave (
        input  nCS, SCLK, MOSI, TX_DATA, TX_LOAD, RX_ACK,
        output MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, OVERRUN
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target engine, oversampling nCS/SCLK/MOSI on MHZ48.
// Define SPI_TARGET_OVERRUN_EN to build the sticky OVERRUN flag.
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input logic          MHZ48,
    input logic          RES,
    spi_target_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StActive} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] csSync, sclkSync, mosiSync;
    logic                   csHist, sclkHist, mosiHist;
    logic [SYNC_STAGES:0]   flushQ;
    logic                   csArmed;
    logic [2:0]             bitCnt;
    logic [6:0]             rxShift;
    logic [6:0]             shiftOut;
    logic [7:0]             txHold;
    logic                   txReadyQ, misoQ, misoOeQ, rxValidQ;
    logic [7:0]             rxDataQ;

    logic       csOut, sclkOut;
    logic       csFall, csRise, sclkRise, sclkFall;
    logic       complete, reload, txLoadOk;
    logic [7:0] nextByte;

    assign csOut    = csSync[SYNC_STAGES-1];
    assign sclkOut  = sclkSync[SYNC_STAGES-1];
    // A fall is only honoured once nCS has been seen high after reset, so a
    // transfer already running at reset release is never joined mid-byte.
    assign csFall   = csHist & ~csOut & csArmed;
    assign csRise   = ~csHist & csOut;
    assign sclkRise = ~sclkHist & sclkOut;
    assign sclkFall = sclkHist & ~sclkOut;

    assign complete = (state == StActive) && !csRise && sclkRise && (bitCnt == 3'd7);
    assign reload   = ((state == StIdle) && csFall) || complete;
    assign nextByte = txReadyQ ? IDLE_BYTE : txHold;
    assign txLoadOk = bus.TX_LOAD & txReadyQ;

    always_ff @(posedge MHZ48) begin
        if (RES) begin
            state    <= StIdle;
            csSync   <= '1;
            sclkSync <= '0;
            mosiSync <= '1;
            csHist   <= 1'b1;
            sclkHist <= 1'b0;
            mosiHist <= 1'b1;
            flushQ   <= '0;
            csArmed  <= 1'b0;
            bitCnt   <= 3'd0;
            rxShift  <= '0;
            shiftOut <= '1;
            txHold   <= '0;
            txReadyQ <= 1'b1;
            misoQ    <= 1'b1;
            misoOeQ  <= 1'b0;
            rxValidQ <= 1'b0;
            rxDataQ  <= 8'h00;
        end else begin
            csSync   <= {csSync[SYNC_STAGES-2:0], bus.nCS};
            sclkSync <= {sclkSync[SYNC_STAGES-2:0], bus.SCLK};
            mosiSync <= {mosiSync[SYNC_STAGES-2:0], bus.MOSI};
            csHist   <= csOut;
            sclkHist <= sclkOut;
            mosiHist <= mosiSync[SYNC_STAGES-1];
            flushQ   <= {flushQ[SYNC_STAGES-1:0], 1'b1};
            if (flushQ[SYNC_STAGES] && csOut) begin
                csArmed <= 1'b1;
            end

            if (reload) begin
                shiftOut <= nextByte[6:0];
                misoQ    <= nextByte[7];
            end
            if (txLoadOk) begin
                txHold   <= bus.TX_DATA;
                txReadyQ <= 1'b0;
            end else if (reload) begin
                txReadyQ <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (csFall) begin
                        state   <= StActive;
                        misoOeQ <= 1'b1;
                        bitCnt  <= 3'd0;
                    end
                end
                StActive: begin
                    if (csRise) begin
                        state   <= StIdle;
                        misoOeQ <= 1'b0;
                        misoQ   <= 1'b1;
                        bitCnt  <= 3'd0;
                    end else begin
                        if (sclkRise) begin
                            rxShift <= {rxShift[5:0], mosiHist};
                            bitCnt  <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                rxDataQ <= {rxShift, mosiHist};
                            end
                        end
                        // The fall after the 8th rise must not disturb the freshly reloaded bit 7.
                        if (sclkFall && (bitCnt != 3'd0)) begin
                            misoQ    <= shiftOut[6];
                            shiftOut <= {shiftOut[5:0], 1'b1};
                        end
                    end
                end
                default: state <= StIdle;
            endcase

            if (complete) begin
                rxValidQ <= 1'b1;
            end else if (bus.RX_ACK) begin
                rxValidQ <= 1'b0;
            end
        end
    end

`ifdef SPI_TARGET_OVERRUN_EN
    logic overrunQ;

    always_ff @(posedge MHZ48) begin
        if (RES) begin
            overrunQ <= 1'b0;
        end else if (complete && rxValidQ && !bus.RX_ACK) begin
            overrunQ <= 1'b1;
        end else if (bus.RX_ACK) begin
            overrunQ <= 1'b0;
        end
    end

    assign bus.OVERRUN = overrunQ;
`else
    assign bus.OVERRUN = 1'b0;
`endif

    assign bus.MISO     = misoQ;
    assign bus.MISO_OE  = misoOeQ;
    assign bus.TX_READY = txReadyQ;
    assign bus.RX_DATA  = rxDataQ;
    assign bus.RX_VALID = rxValidQ;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-banged SPI master with hand-computed expectations.
module tb_spi_target;
    logic MHZ48 = 1'b0;
    logic RES;

    spi_target_if bus ();

    spi_target #(
        .SYNC_STAGES(2),
        .IDLE_BYTE  (8'hFF)
    ) dut (
        .MHZ48(MHZ48),
        .RES  (RES),
        .bus  (bus)
    );

    always #10 MHZ48 = ~MHZ48;

`ifdef SPI_TARGET_OVERRUN_EN
    localparam logic [7:0] ExpOverrun = 8'd1;
`else
    localparam logic [7:0] ExpOverrun = 8'd0;
`endif

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge MHZ48);
    endtask

    // Clocks nBits of mosiByte MSB first; MISO is sampled just before each rising SCLK.
    task automatic spiBits(input logic [7:0] mosiByte, input int nBits,
                           output logic [7:0] misoByte);
        logic [7:0] shifted;
        shifted  = mosiByte;
        misoByte = 8'h00;
        for (int i = 0; i < nBits; i++) begin
            bus.MOSI = shifted[7];
            shifted  = {shifted[6:0], 1'b0};
            waitClks(8);
            misoByte = {misoByte[6:0], bus.MISO};
            bus.SCLK = 1'b1;
            waitClks(8);
            bus.SCLK = 1'b0;
            waitClks(8);
        end
    endtask

    task automatic csLow();
        bus.nCS = 1'b0;
        waitClks(8);
    endtask

    task automatic csHigh();
        bus.nCS = 1'b1;
        waitClks(8);
    endtask

    task automatic txLoad(input logic [7:0] b);
        bus.TX_DATA = b;
        bus.TX_LOAD = 1'b1;
        waitClks(1);
        bus.TX_LOAD = 1'b0;
        waitClks(1);
    endtask

    task automatic rxAck();
        bus.RX_ACK = 1'b1;
        waitClks(1);
        bus.RX_ACK = 1'b0;
        waitClks(1);
    endtask

    logic [7:0] misoByte;

    initial begin
        RES         = 1'b1;
        bus.nCS     = 1'b1;
        bus.SCLK    = 1'b0;
        bus.MOSI    = 1'b1;
        bus.TX_DATA = 8'h00;
        bus.TX_LOAD = 1'b0;
        bus.RX_ACK  = 1'b0;
        waitClks(4);
        RES = 1'b0;
        waitClks(8);

        // Reset / idle state
        checkVal("rst_miso", {7'd0, bus.MISO}, 8'd1);
        checkVal("rst_oe", {7'd0, bus.MISO_OE}, 8'd0);
        checkVal("rst_txready", {7'd0, bus.TX_READY}, 8'd1);
        checkVal("rst_rxvalid", {7'd0, bus.RX_VALID}, 8'd0);
        checkVal("rst_rxdata", bus.RX_DATA, 8'h00);
        checkVal("rst_overrun", {7'd0, bus.OVERRUN}, 8'd0);

        // Single byte: TX A5 out, 3C in
        txLoad(8'hA5);
        checkVal("load_txready", {7'd0, bus.TX_READY}, 8'd0);
        csLow();
        checkVal("cs_oe", {7'd0, bus.MISO_OE}, 8'd1);
        checkVal("cs_txready", {7'd0, bus.TX_READY}, 8'd1);
        spiBits(8'h3C, 8, misoByte);
        checkVal("b1_miso", misoByte, 8'hA5);
        checkVal("b1_rxdata", bus.RX_DATA, 8'h3C);
        checkVal("b1_rxvalid", {7'd0, bus.RX_VALID}, 8'd1);
        checkVal("b1_txready", {7'd0, bus.TX_READY}, 8'd1);
        rxAck();
        checkVal("b1_ack", {7'd0, bus.RX_VALID}, 8'd0);
        csHigh();
        checkVal("idle_oe", {7'd0, bus.MISO_OE}, 8'd0);
        checkVal("idle_miso", {7'd0, bus.MISO}, 8'd1);

        // Back-to-back bytes; second TX_LOAD while full must be ignored
        txLoad(8'h5C);
        txLoad(8'h99);
        csLow();
        spiBits(8'h12, 8, misoByte);
        checkVal("b2a_miso", misoByte, 8'h5C);
        checkVal("b2a_rxdata", bus.RX_DATA, 8'h12);
        rxAck();
        spiBits(8'h34, 8, misoByte);
        checkVal("b2b_miso", misoByte, 8'hFF);
        checkVal("b2b_rxdata", bus.RX_DATA, 8'h34);
        checkVal("b2b_overrun", {7'd0, bus.OVERRUN}, 8'd0);
        rxAck();
        csHigh();

        // Partial byte aborted by nCS, then a full byte
        csLow();
        spiBits(8'hF0, 5, misoByte);
        csHigh();
        checkVal("part_rxvalid", {7'd0, bus.RX_VALID}, 8'd0);
        checkVal("part_rxdata", bus.RX_DATA, 8'h34);
        csLow();
        spiBits(8'h81, 8, misoByte);
        checkVal("post_rxdata", bus.RX_DATA, 8'h81);
        checkVal("post_rxvalid", {7'd0, bus.RX_VALID}, 8'd1);
        checkVal("post_miso", misoByte, 8'hFF);
        rxAck();
        csHigh();

        // Two bytes without acknowledge
        csLow();
        spiBits(8'h11, 8, misoByte);
        spiBits(8'h22, 8, misoByte);
        checkVal("ovr_rxdata", bus.RX_DATA, 8'h22);
        checkVal("ovr_flag", {7'd0, bus.OVERRUN}, ExpOverrun);
        rxAck();
        checkVal("ovr_ack_valid", {7'd0, bus.RX_VALID}, 8'd0);
        checkVal("ovr_ack_flag", {7'd0, bus.OVERRUN}, 8'd0);
        csHigh();

        // Reset mid-transfer
        csLow();
        txLoad(8'h77);
        spiBits(8'hC3, 4, misoByte);
        RES = 1'b1;
        waitClks(1);
        checkVal("mres_miso", {7'd0, bus.MISO}, 8'd1);
        checkVal("mres_oe", {7'd0, bus.MISO_OE}, 8'd0);
        checkVal("mres_txready", {7'd0, bus.TX_READY}, 8'd1);
        checkVal("mres_rxvalid", {7'd0, bus.RX_VALID}, 8'd0);
        checkVal("mres_rxdata", bus.RX_DATA, 8'h00);
        checkVal("mres_overrun", {7'd0, bus.OVERRUN}, 8'd0);
        RES = 1'b0;
        waitClks(8);
        spiBits(8'h00, 2, misoByte);
        checkVal("mres_noresume", {7'd0, bus.MISO_OE}, 8'd0);
        csHigh();
        csLow();
        spiBits(8'h5A, 8, misoByte);
        checkVal("fresh_rxdata", bus.RX_DATA, 8'h5A);
        checkVal("fresh_rxvalid", {7'd0, bus.RX_VALID}, 8'd1);
        checkVal("fresh_miso", misoByte, 8'hFF);
        csHigh();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
